sprite_blit_sequencer: RTL and testbench

- Sequences the shared ROM reader to stream one sprite or screen image, pixel by pixel, to the frame-buffer writer.
- Accepts a draw command (ROM id, size, screen origin) and issues linear ROM addresses.
- Absorbs the fixed ROM read latency in a credit-controlled pixel FIFO.
- Emits (x, y, colour) pixel writes under a valid/ready handshake.

---
 rtl/sprite_blit_sequencer_pkg.sv | 13 +
 rtl/sprite_blit_sequencer_if.sv | 27 ++
 rtl/sprite_blit_sequencer_fifo.sv | 37 +++
 rtl/sprite_blit_sequencer.sv | 97 +++++++++
 tb/tb_sprite_blit_sequencer.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/sprite_blit_sequencer_pkg.sv
// sprite_blit_pkg: shared states, pixel record and sizing constants for the sprite blitter.
package sprite_blit_pkg;
   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
   typedef struct packed {
      logic [8:0]  x;
      logic [7:0]  y;
      logic [15:0] colour;
   } pixel_t;
   localparam int DEF_READ_LATENCY = 2;
   localparam int DEF_FIFO_DEPTH = 4;
   localparam int SCREEN_W = 320;
   localparam int SCREEN_H = 240;
endpackage

// File: rtl/sprite_blit_sequencer_if.sv
// sprite_blit_if: command, ROM reader and pixel-write signals of the sprite blitter.
interface sprite_blit_if;
   logic        start;
   logic [3:0]  cmd_rom_id;
   logic [8:0]  cmd_width;
   logic [7:0]  cmd_height;
   logic [8:0]  cmd_x0;
   logic [7:0]  cmd_y0;
   logic [3:0]  rom_id;
   logic [15:0] rom_addr;
   logic [15:0] rom_data;
   logic        pix_valid;
   logic        pix_ready;
   logic [8:0]  pix_x;
   logic [7:0]  pix_y;
   logic [15:0] pix_colour;
   logic        busy;
   logic        done;
   modport slave (
      input  start, cmd_rom_id, cmd_width, cmd_height, cmd_x0, cmd_y0, rom_data, pix_ready,
      output rom_id, rom_addr, pix_valid, pix_x, pix_y, pix_colour, busy, done
   );
   modport master (
      output start, cmd_rom_id, cmd_width, cmd_height, cmd_x0, cmd_y0, rom_data, pix_ready,
      input  rom_id, rom_addr, pix_valid, pix_x, pix_y, pix_colour, busy, done
   );
endinterface

// File: rtl/sprite_blit_sequencer_fifo.sv
// sprite_pixel_fifo: synchronous pixel-record FIFO; outputs read as zero while empty.
module sprite_pixel_fifo
   import sprite_blit_pkg::*;
#(
   parameter int DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  pixel_t                   din,
   input  logic                     pop,
   output pixel_t                   dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   pixel_t mem [DEPTH];
   logic [AW-1:0] wr, rd;
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr <= '0;
         rd <= '0;
         count <= '0;
      end else begin
         wr <= push ? wr + 1'b1 : wr;
         rd <= pop ? rd + 1'b1 : rd;
         count <= count + CW'(push) - CW'(pop);
      end
   end
   always_ff @(posedge clock) begin
      if (push) mem[wr] <= din;
   end
   assign empty = count == '0;
   assign dout = empty ? '0 : mem[rd];
   overflow: assert property (@(posedge clock) disable iff (!reset) !(push && !pop && count == CW'(DEPTH)));
endmodule

// File: rtl/sprite_blit_sequencer.sv
// sprite_blit_sequencer: streams a ROM sprite as (x,y,colour) writes; SPRITE_TRANSPARENCY_EN drops key-coloured pixels.
module sprite_blit_sequencer
   import sprite_blit_pkg::*;
#(
   parameter int          READ_LATENCY = DEF_READ_LATENCY,
   parameter int          FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter logic [15:0] TRANSPARENT_COLOUR = 16'hF81F
) (
   input logic          clock,
   input logic          reset,
   sprite_blit_if.slave bus
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int TW = 17 * READ_LATENCY;
`ifdef SPRITE_TRANSPARENCY_EN
   localparam logic KEY_EN = 1'b1;
`else
   localparam logic KEY_EN = 1'b0;
`endif
   state_t state;
   logic [8:0] width, x0, col;
   logic [7:0] height, y0, row;
   logic [READ_LATENCY-1:0] pv;
   logic [READ_LATENCY-1:0][16:0] ptag;
   logic [CW-1:0] fcount, inflight;
   logic empty, issue, push, pop, last_col, last;
   pixel_t din, dout;
   always_comb begin
      inflight = '0;
      for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + CW'(pv[i]);
   end
   // Credits cover both reads still in the ROM and pixels parked in the FIFO.
   assign issue = state == FETCH && (inflight + fcount) < CW'(FIFO_DEPTH);
   assign last_col = col == width - 9'd1;
   assign last = last_col && row == height - 8'd1;
   assign push = pv[READ_LATENCY-1] && !(KEY_EN && bus.rom_data == TRANSPARENT_COLOUR);
   assign pop = !empty && bus.pix_ready;
   assign din = {x0 + ptag[READ_LATENCY-1][16:8], y0 + ptag[READ_LATENCY-1][7:0], bus.rom_data};
   assign bus.pix_valid = !empty;
   assign {bus.pix_x, bus.pix_y, bus.pix_colour} = dout;
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pv <= '0;
         ptag <= '0;
      end else begin
         pv <= READ_LATENCY'({pv, issue});
         ptag <= TW'({ptag, col, row});
      end
   end
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         bus.rom_id <= '0;
         bus.rom_addr <= '0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         {width, height, x0, y0, col, row} <= '0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               bus.rom_id <= bus.cmd_rom_id;
               bus.rom_addr <= '0;
               bus.busy <= 1'b1;
               {width, height, x0, y0} <= {bus.cmd_width, bus.cmd_height, bus.cmd_x0, bus.cmd_y0};
               col <= '0;
               row <= '0;
               state <= FETCH;
            end
            FETCH: if (issue) begin
               bus.rom_addr <= bus.rom_addr + 16'd1;
               col <= last_col ? 9'd0 : col + 9'd1;
               row <= last_col ? row + 8'd1 : row;
               state <= last ? DRAIN : FETCH;
            end
            DRAIN: if (pv == '0 && empty) begin
               bus.busy <= 1'b0;
               bus.done <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               bus.done <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
   sprite_pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock(clock),
      .reset(reset),
      .push(push),
      .din(din),
      .pop(pop),
      .dout(dout),
      .count(fcount),
      .empty(empty)
   );
endmodule

// File: tb/tb_sprite_blit_sequencer.sv
// tb_sprite_blit_sequencer: directed draws checked against a pixel-list model and literal expectations.
module tb_sprite_blit_sequencer;
   import sprite_blit_pkg::*;
   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;
   sprite_blit_if bus();
   sprite_blit_sequencer dut (.clock(clock), .reset(reset), .bus(bus.slave));

   int vec = 0, errs = 0;
   int cyc = 0, start_cyc = 0, first_v = -1, last_acc = 0, done_cyc = 0, done_cnt = 0, acc = 0;
   int rom_mode = 0;
   logic [32:0] exp_q[$];
   logic [32:0] acc_log [64];
   logic [15:0] d1 = '0, d2 = '0;

   function automatic logic [15:0] rom_f(input int mode, input logic [15:0] a);
      return mode == 0 ? a + 16'h0100 : (a[0] ? 16'h1234 : 16'hF81F);
   endfunction

   always @(posedge clock) begin
      cyc <= cyc + 1;
      d1 <= rom_f(rom_mode, bus.rom_addr);
      d2 <= d1;
   end
   assign bus.rom_data = d2;

   always @(negedge clock) if (reset) begin
      if (bus.pix_valid) begin
         if (first_v < 0) first_v = cyc;
         vec++;
         if (exp_q.size() == 0) begin
            errs++;
            $display("FAIL pixel: got x=%0d y=%0d c=%h, required none", bus.pix_x, bus.pix_y, bus.pix_colour);
         end else if ({bus.pix_x, bus.pix_y, bus.pix_colour} !== exp_q[0]) begin
            errs++;
            $display("FAIL pixel: got x=%0d y=%0d c=%h, required x=%0d y=%0d c=%h", bus.pix_x, bus.pix_y,
                     bus.pix_colour, exp_q[0][32:24], exp_q[0][23:16], exp_q[0][15:0]);
         end
         if (bus.pix_ready) begin
            if (exp_q.size() > 0) exp_q.delete(0);
            if (acc < 64) acc_log[acc] = {bus.pix_x, bus.pix_y, bus.pix_colour};
            acc++;
            last_acc = cyc + 1;
         end
      end
      if (bus.done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      vec++;
      if (act !== req) begin
         errs++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic check_zero(input string name);
      chk({name, " rom_id"}, 64'(bus.rom_id), 0);
      chk({name, " rom_addr"}, 64'(bus.rom_addr), 0);
      chk({name, " pix_valid"}, 64'(bus.pix_valid), 0);
      chk({name, " pix_x"}, 64'(bus.pix_x), 0);
      chk({name, " pix_y"}, 64'(bus.pix_y), 0);
      chk({name, " pix_colour"}, 64'(bus.pix_colour), 0);
      chk({name, " busy"}, 64'(bus.busy), 0);
      chk({name, " done"}, 64'(bus.done), 0);
   endtask

   // Expected pixels: raster order, ROM address = row*width+col, 9/8-bit screen wrap.
   task automatic cmd(input logic [3:0] id, input int w, input int h, input logic [8:0] x, input logic [7:0] y);
      for (int r = 0; r < h; r++)
         for (int c = 0; c < w; c++) begin
            logic [15:0] col = rom_f(rom_mode, 16'(r * w + c));
`ifdef SPRITE_TRANSPARENCY_EN
            if (col == 16'hF81F) continue;
`endif
            exp_q.push_back({9'(int'(x) + c), 8'(int'(y) + r), col});
         end
      acc = 0;
      first_v = -1;
      bus.cmd_rom_id = id;
      bus.cmd_width = 9'(w);
      bus.cmd_height = 8'(h);
      bus.cmd_x0 = x;
      bus.cmd_y0 = y;
      bus.start = 1'b1;
      @(posedge clock);
      #1;
      start_cyc = cyc;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int d0 = done_cnt;
      bit got = 1'b0;
      for (int i = 0; i < 2000 && !got; i++) begin
         @(posedge clock);
         got = done_cnt != d0;
      end
      #1;
      vec++;
      if (!got) begin
         errs++;
         $display("FAIL %s: done not seen within 2000 clocks, required a pulse", name);
      end
      chk({name, " drained"}, 64'(exp_q.size()), 0);
   endtask

   initial begin
      int d0;
      {bus.start, bus.cmd_rom_id, bus.cmd_width, bus.cmd_height, bus.cmd_x0, bus.cmd_y0} = '0;
      bus.pix_ready = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check_zero("reset");
      reset = 1'b1;
      @(posedge clock);
      #1;

      cmd(4'd1, 2, 2, 9'd10, 8'd5);
      wait_done("t1");
      chk("t1 first valid latency", 64'(first_v - start_cyc), 3);
      chk("t1 done after last accept", 64'(done_cyc - last_acc), 1);
      chk("t1 done cycle", 64'(done_cyc - start_cyc), 8);
      chk("t1 px0", 64'(acc_log[0]), {31'd0, 9'd10, 8'd5, 16'h0100});
      chk("t1 px3", 64'(acc_log[3]), {31'd0, 9'd11, 8'd6, 16'h0103});
      chk("t1 count", 64'(acc), 4);
      chk("t1 busy low", 64'(bus.busy), 0);

      bus.pix_ready = 1'b0;
      cmd(4'd3, 8, 1, 9'd0, 8'd0);
      repeat (10) @(posedge clock);
      #1;
      chk("t2 rom_addr stall", 64'(bus.rom_addr), 4);
      chk("t2 pix_valid", 64'(bus.pix_valid), 1);
      chk("t2 busy", 64'(bus.busy), 1);
      bus.pix_ready = 1'b1;
      wait_done("t2");
      chk("t2 count", 64'(acc), 8);
      chk("t2 first colour", 64'(acc_log[0][15:0]), 16'h0100);
      chk("t2 last colour", 64'(acc_log[7][15:0]), 16'h0107);

      cmd(4'd5, 4, 2, 9'd20, 8'd30);
      repeat (2) @(posedge clock);
      #1;
      {bus.cmd_rom_id, bus.cmd_width, bus.cmd_height, bus.cmd_x0, bus.cmd_y0} = {4'd9, 9'd1, 8'd1, 9'd0, 8'd0};
      bus.start = 1'b1;
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      chk("t3 rom_id kept", 64'(bus.rom_id), 5);
      wait_done("t3a");
      chk("t3a count", 64'(acc), 8);
      cmd(4'd6, 3, 1, 9'd1, 8'd2);
      chk("t3b accepted busy", 64'(bus.busy), 1);
      chk("t3b rom_id", 64'(bus.rom_id), 6);
      wait_done("t3b");
      chk("t3b count", 64'(acc), 3);

      cmd(4'd4, 16, 16, 9'd100, 8'd100);
      repeat (6) @(posedge clock);
      #1;
      d0 = done_cnt;
      reset = 1'b0;
      #1;
      check_zero("mid reset");
      exp_q.delete();
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      repeat (5) @(posedge clock);
      #1;
      chk("t4 no done", 64'(done_cnt), 64'(d0));
      chk("t4 idle", 64'(bus.busy), 0);
      cmd(4'd2, 1, 1, 9'd7, 8'd8);
      wait_done("t4");
      chk("t4 count", 64'(acc), 1);
      chk("t4 px0", 64'(acc_log[0]), {31'd0, 9'd7, 8'd8, 16'h0100});

      rom_mode = 1;
      cmd(4'd8, 4, 1, 9'd40, 8'd50);
      wait_done("t5");
`ifdef SPRITE_TRANSPARENCY_EN
      chk("t5 count", 64'(acc), 2);
      chk("t5 px0", 64'(acc_log[0]), {31'd0, 9'd41, 8'd50, 16'h1234});
      chk("t5 px1", 64'(acc_log[1]), {31'd0, 9'd43, 8'd50, 16'h1234});
`else
      chk("t5 count", 64'(acc), 4);
      chk("t5 px0", 64'(acc_log[0]), {31'd0, 9'd40, 8'd50, 16'hF81F});
      chk("t5 px3", 64'(acc_log[3]), {31'd0, 9'd43, 8'd50, 16'h1234});
`endif
      rom_mode = 0;

      cmd(4'd1, 2, 2, 9'd319, 8'd239);
      wait_done("t6a");
      chk("t6a px1", 64'(acc_log[1]), {31'd0, 9'd320, 8'd239, 16'h0101});
      chk("t6a px3", 64'(acc_log[3]), {31'd0, 9'd320, 8'd240, 16'h0103});
      cmd(4'd1, 2, 2, 9'd511, 8'd255);
      wait_done("t6b");
      chk("t6b px1", 64'(acc_log[1]), {31'd0, 9'd0, 8'd255, 16'h0101});
      chk("t6b px2", 64'(acc_log[2]), {31'd0, 9'd511, 8'd0, 16'h0102});

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
